fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined RV32I core.
- Owns the architectural fetch PC and issues one instruction-memory request at a time.
- Absorbs variable memory latency and delivers {pc, instruction} to decode through the IF/ID register with a valid/ready handshake.
- Handles redirects from execute (branch/jump) by reloading the PC and discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 86 ++++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Holds the fetch FSM states, the NOP encoding and the IF/ID bundle.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry IF/ID buffer: the decode-facing slot plus one hold slot.
// A push lands in IF/ID when it is free after this cycle's pop, else in hold.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_pc_i,
  input  logic [31:0]      push_instr_i,
  input  logic             flush_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] pc_o,
  output logic [31:0]      instr_o,
  output logic             full_o
);

  logic             v0_q, v0_d;
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] pc0_q, pc0_d;
  logic [WIDTH-1:0] pc1_q, pc1_d;
  logic [31:0]      in0_q, in0_d;
  logic [31:0]      in1_q, in1_d;

  // Next-state: flush wins, then pop shifts hold forward, then push fills
  always_comb begin
    v0_d  = v0_q;
    v1_d  = v1_q;
    pc0_d = pc0_q;
    pc1_d = pc1_q;
    in0_d = in0_q;
    in1_d = in1_q;
    if (flush_i) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else begin
      if (pop_i && v0_q) begin
        if (v1_q) begin
          pc0_d = pc1_q;
          in0_d = in1_q;
        end
        v0_d = v1_q;
        v1_d = 1'b0;
      end
      if (push_i) begin
        if (!v0_d) begin
          v0_d  = 1'b1;
          pc0_d = push_pc_i;
          in0_d = push_instr_i;
        end else begin
          v1_d  = 1'b1;
          pc1_d = push_pc_i;
          in1_d = push_instr_i;
        end
      end
    end
  end

  // Slot registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      pc0_q <= '0;
      pc1_q <= '0;
      in0_q <= INSTR_NOP;
      in1_q <= INSTR_NOP;
    end else begin
      v0_q  <= v0_d;
      v1_q  <= v1_d;
      pc0_q <= pc0_d;
      pc1_q <= pc1_d;
      in0_q <= in0_d;
      in1_q <= in1_d;
    end
  end

  assign valid_o = v0_q;
  assign pc_o    = pc0_q;
  assign instr_o = v0_q ? in0_q : INSTR_NOP;
  assign full_o  = v1_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, one-outstanding imem request FSM, IF/ID handoff.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int             WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             id_ready,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [31:0]      if_instr,
  output logic [WIDTH-1:0] if_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_dropped
`endif
);

  fetch_state_e     state_q;
  logic [WIDTH-1:0] pc_q;
  logic             full;
  logic             hs;
  logic             rsp_take;
  logic [WIDTH-1:0] redir_pc;
  logic             unused_lo;

  assign unused_lo = ^redirect_pc[1:0];
  assign redir_pc  = {redirect_pc[WIDTH-1:2], 2'b00};

  // Request is a function of registered state; reset only masks it
  assign imem_req_valid = !reset && (state_q == S_REQ) && !full;
  assign imem_req_addr  = pc_q;
  assign hs             = imem_req_valid && imem_req_ready;
  assign rsp_take       = (state_q == S_WAIT) && imem_rsp_valid
                          && !redirect_valid;

  // Fetch FSM and PC; a redirect overrides every other event
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redir_pc;
      unique case (state_q)
        S_REQ:   state_q <= hs ? S_DROP : S_REQ;
        S_WAIT:  state_q <= imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state_q <= imem_rsp_valid ? S_REQ : S_DROP;
        default: state_q <= S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: if (hs) state_q <= S_WAIT;
        S_WAIT: if (imem_rsp_valid) begin
          pc_q    <= pc_q + WIDTH'(4);
          state_q <= S_REQ;
        end
        S_DROP: if (imem_rsp_valid) state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase
    end
  end

  fetch_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (rsp_take),
    .push_pc_i   (pc_q),
    .push_instr_i(imem_rsp_data),
    .flush_i     (redirect_valid),
    .pop_i       (if_valid && id_ready),
    .valid_o     (if_valid),
    .pc_o        (if_pc),
    .instr_o     (if_instr),
    .full_o      (full)
  );

  assign if_pc_plus4 = if_pc + WIDTH'(4);

`ifdef FETCH_PERF_EN
  logic rsp_drop;
  assign rsp_drop = imem_rsp_valid
                    && ((state_q == S_DROP)
                    || ((state_q == S_WAIT) && redirect_valid));

  // Responses delivered vs. discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (rsp_take) perf_fetched <= perf_fetched + 32'd1;
      if (rsp_drop) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`else
  // No performance counters in this build
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small variable-latency imem stub.
// Define FETCH_PERF_EN to also check the perf counters.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b1;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int          lat = 1;
  logic        use_dead = 1'b0;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_pc_plus4   (if_pc_plus4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_dropped  (perf_dropped)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  // imem stub: response arrives `lat` cycles after the handshake
  always @(posedge clk) begin
    if (reset) begin
      pend           <= 1'b0;
      cnt            <= 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end else begin
      imem_rsp_valid <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        if (lat == 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= use_dead ? 32'hDEAD_BEEF
                                     : instr_of(imem_req_addr);
        end else begin
          pend  <= 1'b1;
          cnt   <= lat - 1;
          paddr <= imem_req_addr;
        end
      end else if (pend) begin
        if (cnt == 1) begin
          pend           <= 1'b0;
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= use_dead ? 32'hDEAD_BEEF : instr_of(paddr);
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench inside cycle 1 (reset low, no edge yet)
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // reset state, held over several edges
    tick();
    tick();
    tick();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, INSTR_NOP);
    check("rst_pc_plus4", if_pc_plus4, 32'h4);

    // streaming, 1-cycle memory, decode always ready
    reset = 1'b0;
    #1;
    check("c1_req_valid", 32'(imem_req_valid), 32'd1);
    check("c1_req_addr", imem_req_addr, 32'h0);
    tick();
    check("c2_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    check("c3_req_addr", imem_req_addr, 32'h4);
    check("c3_if_valid", 32'(if_valid), 32'd1);
    check("c3_if_pc", if_pc, 32'h0);
    check("c3_if_instr", if_instr, instr_of(32'h0));
    check("c3_plus4", if_pc_plus4, 32'h4);
    tick();
    check("c4_if_valid", 32'(if_valid), 32'd0);
    check("c4_if_instr", if_instr, INSTR_NOP);
    tick();
    check("c5_req_addr", imem_req_addr, 32'h8);
    check("c5_if_pc", if_pc, 32'h4);
    check("c5_plus4", if_pc_plus4, 32'h8);
    tick();
    tick();
    check("c7_if_valid", 32'(if_valid), 32'd1);
    check("c7_if_pc", if_pc, 32'h8);
    check("c7_plus4", if_pc_plus4, 32'hC);

    // decode stall: hold slot fills, requests stop
    do_reset();
    id_ready = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("st5_req_valid", 32'(imem_req_valid), 32'd0);
    check("st5_if_pc", if_pc, 32'h0);
    tick();
    check("st6_req_valid", 32'(imem_req_valid), 32'd0);
    check("st6_if_valid", 32'(if_valid), 32'd1);
    tick();
    id_ready = 1'b1;
    #1;
    check("st7_if_pc", if_pc, 32'h0);
    check("st7_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    check("st8_if_pc", if_pc, 32'h4);
    check("st8_if_instr", if_instr, instr_of(32'h4));
    check("st8_req_valid", 32'(imem_req_valid), 32'd1);
    check("st8_req_addr", imem_req_addr, 32'h8);

    // redirect while waiting on a 3-cycle response
    lat = 3;
    do_reset();
    tick();
    use_dead = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("rw2_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check("rw3_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    check("rw4_rsp_seen", 32'(imem_rsp_valid), 32'd1);
    tick();
    check("rw5_if_valid", 32'(if_valid), 32'd0);
    check("rw5_req_valid", 32'(imem_req_valid), 32'd1);
    check("rw5_req_addr", imem_req_addr, 32'h100);
    lat = 1;
    use_dead = 1'b0;
    tick();
    tick();
    check("rw7_if_pc", if_pc, 32'h100);
    check("rw7_if_instr", if_instr, instr_of(32'h100));

    // redirect coincident with the response
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("rc3_if_valid", 32'(if_valid), 32'd0);
    check("rc3_req_valid", 32'(imem_req_valid), 32'd1);
    check("rc3_req_addr", imem_req_addr, 32'h40);
    tick();
    tick();
    check("rc5_if_pc", if_pc, 32'h40);
    check("rc5_req_addr", imem_req_addr, 32'h44);
    tick();
    tick();
    tick();
    tick();
    check("rc9_req_addr", imem_req_addr, 32'h4C);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'd3);
    check("perf_dropped", perf_dropped, 32'd1);
`endif

    // misaligned redirect target is forced to a word address
    do_reset();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("al_req_valid", 32'(imem_req_valid), 32'd1);
    check("al_req_addr", imem_req_addr, 32'h200);

    // PC wraps past the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wr_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    tick();
    check("wr_req_addr1", imem_req_addr, 32'h0);
    check("wr_if_pc", if_pc, 32'hFFFF_FFFC);
    check("wr_plus4", if_pc_plus4, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
